// File: rtl/sdr_16_dq_path_pkg.sv
// sdr_16_dq_path_pkg: CAS-latency encodings, beat ordering and data types shared by the DQ path and the FSM
package sdr_16_dq_path_pkg;

    // CL field values the FSM programs via LMR; the capture delay line must match one of these
    localparam int CL_ENC_2 = 2;
    localparam int CL_ENC_3 = 3;

    // The upper half-word is always the first beat of a burst
    localparam bit BEAT_UPPER_FIRST = 1'b1;

    typedef logic [15:0] beat_t;
    typedef logic [31:0] word_t;

    // Selects the half-word for a beat phase; phase 0 is the first beat
    function automatic beat_t sel_beat(input word_t w, input logic phase);
        return (phase == BEAT_UPPER_FIRST) ? w[15:0] : w[31:16];
    endfunction

endpackage

// File: rtl/sdr_16_dq_path_rd_capture.sv
// sdr_16_rd_capture: CL delay line, DQ input register, beat packing, in-flight counter and overflow flag
module sdr_16_rd_capture
    import sdr_16_dq_path_pkg::*;
#(
    parameter int CL     = 2,
    parameter int PEND_W = 3
) (
    input  logic       sdram_clk,
    input  logic       sdram_rst,
    input  logic       cmd_read,
    input  beat_t      dq_i,
    input  logic       fifo_full,
    output word_t      rd_data,
    output logic       sdram_fifo_wr,
    output logic       rd_pending,
    output logic       overflow,
    output logic [1:0] beat_v_o
);

    // dly_q[0] is cmd_read one cycle late; v0/v1 line up with din_q holding the first/second beat
    logic [CL+1:0]     dly_q;
    beat_t             din_q;
    beat_t             hi_q;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic              ovf_q;
    logic              v0;
    logic              v1;

    assign v0 = dly_q[CL];
    assign v1 = dly_q[CL+1];

    // Saturating in-flight count: +1 per READ issued, -1 per word delivered
    always_comb begin
        pend_d = (cmd_read && !v1 && !(&pend_q)) ? pend_q + 1'b1 :
                 (v1 && !cmd_read && (|pend_q))  ? pend_q - 1'b1 : pend_q;
    end

    // Delay line, input register, first-beat hold and sticky overflow
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            dly_q  <= '0;
            din_q  <= '0;
            hi_q   <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            dly_q  <= {dly_q[CL:0], cmd_read};
            din_q  <= dq_i;
            hi_q   <= v0 ? din_q : hi_q;
            pend_q <= pend_d;
            ovf_q  <= ovf_q | (v1 & fifo_full);
        end
    end

    // The FSM never issues READs in adjacent cycles; bursts would overlap in the delay line
    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst) assert (!(cmd_read && dly_q[0]));
    end

    // The second beat is still in din_q when v1 is high, so the word completes without an extra stage
    assign rd_data       = {hi_q, din_q};
    assign sdram_fifo_wr = v1;
    assign rd_pending    = |pend_q;
    assign overflow      = ovf_q;
    assign beat_v_o      = {v1, v0};

endmodule

// File: rtl/sdr_16_dq_path.sv
// sdr_16_dq_path: registered write beats onto DQ plus the read capture stage toward the ingress FIFO
module sdr_16_dq_path
    import sdr_16_dq_path_pkg::*;
#(
    parameter int CL     = 2,
    parameter int PEND_W = 3
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic        cmd_read,
    input  logic        count0,
    input  logic        wr_active,
    input  logic [31:0] wr_data,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe_o,
    output logic [31:0] rd_data,
    output logic        sdram_fifo_wr,
    input  logic        fifo_full,
    output logic        rd_pending,
    output logic        overflow
);

    if (CL != CL_ENC_2 && CL != CL_ENC_3) begin : g_bad_cl
        $error("sdr_16_dq_path: CL must be 2 or 3");
    end

    beat_t      dq_q;
    logic       oe_q;
    logic [1:0] beat_v;

    // Write beats are registered so they meet the FSM's registered command/DQM on the pins
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            dq_q <= '0;
            oe_q <= 1'b0;
        end else begin
            dq_q <= wr_active ? sel_beat(wr_data, count0) : '0;
            oe_q <= wr_active;
        end
    end

    // Turnaround belongs to the FSM; driving DQ while read beats are landing is a bus fight
    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst) assert (!(oe_q && (|beat_v)));
    end

    assign dq_o    = dq_q;
    assign dq_oe_o = oe_q;

    sdr_16_rd_capture #(
        .CL     (CL),
        .PEND_W (PEND_W)
    ) u_rd_capture (
        .sdram_clk     (sdram_clk),
        .sdram_rst     (sdram_rst),
        .cmd_read      (cmd_read),
        .dq_i          (dq_i),
        .fifo_full     (fifo_full),
        .rd_data       (rd_data),
        .sdram_fifo_wr (sdram_fifo_wr),
        .rd_pending    (rd_pending),
        .overflow      (overflow),
        .beat_v_o      (beat_v)
    );

endmodule

// File: tb/tb_sdr_16_dq_path.sv
// tb_sdr_16_dq_path: random and directed stimulus on CL=2 and CL=3 instances, checked against a cycle-history model
module tb_sdr_16_dq_path;

    localparam int MAXC = 8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd, wa, c0, full;
    logic [31:0] wd;
    logic [15:0] dq;

    logic [15:0] dq_o2, dq_o3;
    logic        oe2, oe3, wr2, wr3, pend2, pend3, ovf2, ovf3;
    logic [31:0] rd2, rd3;

    int cyc = -1;
    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    logic        a_rst[MAXC], a_cmd[MAXC], a_wa[MAXC], a_c0[MAXC], a_full[MAXC];
    logic [31:0] a_wd[MAXC];
    logic [15:0] a_dq[MAXC];

    sdr_16_dq_path #(.CL(2), .PEND_W(3)) u_cl2 (
        .sdram_clk(clk), .sdram_rst(rst), .cmd_read(cmd), .count0(c0), .wr_active(wa),
        .wr_data(wd), .dq_i(dq), .dq_o(dq_o2), .dq_oe_o(oe2), .rd_data(rd2),
        .sdram_fifo_wr(wr2), .fifo_full(full), .rd_pending(pend2), .overflow(ovf2)
    );

    sdr_16_dq_path #(.CL(3), .PEND_W(3)) u_cl3 (
        .sdram_clk(clk), .sdram_rst(rst), .cmd_read(cmd), .count0(c0), .wr_active(wa),
        .wr_data(wd), .dq_i(dq), .dq_o(dq_o3), .dq_oe_o(oe3), .rd_data(rd3),
        .sdram_fifo_wr(wr3), .fifo_full(full), .rd_pending(pend3), .overflow(ovf3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus: inputs change just after the edge and are logged by cycle index
    task automatic step(input logic r, input logic cm, input logic w, input logic c,
                        input logic f, input logic [31:0] d, input logic [15:0] q);
        @(posedge clk);
        #1;
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 2);
            $fatal(1);
        end
        cyc++;
        rst = r; cmd = cm; wa = w; c0 = c; full = f; wd = d; dq = q;
        a_rst[cyc] = r; a_cmd[cyc] = cm; a_wa[cyc] = w; a_c0[cyc] = c;
        a_full[cyc] = f; a_wd[cyc] = d; a_dq[cyc] = q;
    endtask

    function automatic bit rnd(input int n);
        return $urandom_range(0, n - 1) == 0;
    endfunction

    // A READ at t0 delivers its word at t0+cl+2 unless a reset was applied in between
    function automatic bit strobe_at(input int j, input int cl);
        int t0 = j - cl - 2;
        if (t0 < 0) return 1'b0;
        if (a_cmd[t0] !== 1'b1) return 1'b0;
        for (int t = t0; t < j; t++) if (a_rst[t]) return 1'b0;
        return 1'b1;
    endfunction

    int mcnt[2] = '{0, 0};
    bit movf[2] = '{1'b0, 1'b0};

    task automatic cmp(input int i, input int cl, input logic [15:0] o_dq, input logic o_oe,
                       input logic [31:0] o_rd, input logic o_wr, input logic o_pend, input logic o_ovf);
        int k = cyc;
        bit s = strobe_at(k, cl);
        logic [15:0] edq;
        bit eoe;
        string p = $sformatf("cl%0d", cl);
        eoe = !a_rst[k-1] && a_wa[k-1];
        edq = eoe ? (a_c0[k-1] ? a_wd[k-1][15:0] : a_wd[k-1][31:16]) : 16'h0;
        chk({p, ".dq_o"}, {16'h0, o_dq}, {16'h0, edq});
        chk({p, ".dq_oe_o"}, {31'h0, o_oe}, {31'h0, eoe});
        chk({p, ".fifo_wr"}, {31'h0, o_wr}, {31'h0, s});
        chk({p, ".rd_pending"}, {31'h0, o_pend}, {31'h0, mcnt[i] != 0});
        chk({p, ".overflow"}, {31'h0, o_ovf}, {31'h0, movf[i]});
        if (s) chk({p, ".rd_data"}, o_rd, {a_dq[k-2], a_dq[k-1]});
        if (a_rst[k-1]) chk({p, ".rd_data_rst"}, o_rd, 32'h0);
        if (a_rst[k]) begin
            mcnt[i] = 0;
            movf[i] = 1'b0;
        end else begin
            mcnt[i] = mcnt[i] + int'(a_cmd[k]) - int'(s);
            movf[i] = movf[i] | (s & a_full[k]);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && !done) begin
            cmp(0, 2, dq_o2, oe2, rd2, wr2, pend2, ovf2);
            cmp(1, 3, dq_o3, oe3, rd3, wr3, pend3, ovf3);
        end
    end

    initial begin
        rst = 1'b1; cmd = 1'b0; wa = 1'b0; c0 = 1'b0; full = 1'b0; wd = '0; dq = '0;
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);

        step(0, 0, 0, 0, 0, 0, 0);
        chk("lit.reset_dq_o", {16'h0, dq_o2}, 32'h0);
        chk("lit.reset_oe", {31'h0, oe2}, 32'h0);
        chk("lit.reset_rd_data", rd2, 32'h0);
        chk("lit.reset_pending", {31'h0, pend3}, 32'h0);
        repeat (9) step(0, 0, 0, 0, 0, 0, 0);

        step(0, 0, 1, 0, 0, 32'hCAFE_1234, 0);
        step(0, 0, 1, 1, 0, 32'hCAFE_1234, 0);
        chk("lit.wr_beat0", {16'h0, dq_o2}, 32'h0000_CAFE);
        chk("lit.wr_oe0", {31'h0, oe2}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lit.wr_beat1", {16'h0, dq_o2}, 32'h0000_1234);
        chk("lit.wr_oe1", {31'h0, oe2}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lit.wr_oe_off", {31'h0, oe2}, 32'h0);

        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lit.cl2_pending", {31'h0, pend2}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 16'hDEAD);
        step(0, 0, 0, 0, 0, 0, 16'hBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lit.cl2_strobe", {31'h0, wr2}, 32'h1);
        chk("lit.cl2_word", rd2, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lit.cl2_pending_done", {31'h0, pend2}, 32'h0);
        repeat (6) step(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step(0, (i < 8) && (i % 2 == 0), 0, 0, 0, 0, 16'(32'h1000 + i));
            if (i == 5) begin
                chk("lit.cl3_strobe0", {31'h0, wr3}, 32'h1);
                chk("lit.cl3_word0", rd3, 32'h1003_1004);
            end
            if (i == 11) chk("lit.cl3_word3", rd3, 32'h1009_100A);
        end
        repeat (6) step(0, 0, 0, 0, 0, 0, 0);

        step(0, 1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 16'h5A5A);
        step(0, 0, 0, 0, 1, 0, 16'h0);
        chk("lit.ovf_strobe", {31'h0, wr2}, 32'h1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("lit.ovf_set", {31'h0, ovf2}, 32'h1);
        repeat (5) step(0, 0, 0, 0, 0, 0, 0);
        chk("lit.ovf_sticky", {31'h0, ovf2}, 32'h1);

        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 16'h1111);
        step(0, 0, 0, 0, 0, 0, 16'h2222);
        step(1, 0, 0, 0, 0, 0, 16'h3333);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lit.rst_no_strobe", {31'h0, wr2}, 32'h0);
        chk("lit.rst_pending", {31'h0, pend2}, 32'h0);
        chk("lit.rst_rd_data", rd2, 32'h0);
        chk("lit.rst_ovf", {31'h0, ovf2}, 32'h0);
        repeat (6) step(0, 0, 0, 0, 0, 0, 0);

        repeat (100) begin
            if ($urandom_range(0, 1) == 0) begin
                int n = $urandom_range(1, 5);
                for (int j = 0; j < n; j++) begin
                    step(rnd(40), 1, 0, 0, rnd(4), 0, 16'($urandom));
                    repeat ($urandom_range(1, 2)) step(0, 0, 0, 0, rnd(4), 0, 16'($urandom));
                end
                repeat (7) step(0, 0, 0, 0, rnd(4), 0, 16'($urandom));
            end else begin
                int n = $urandom_range(1, 6);
                logic [31:0] d = $urandom;
                for (int j = 0; j < n; j++) step(0, 0, 1, j[0], rnd(4), d, 16'($urandom));
                step(0, 0, 0, 0, 0, 0, 16'($urandom));
            end
        end

        repeat (4) step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
